booth_mac_acc: RTL and testbench

BOOTH_MAC_ACC -- requirements
Module: booth_mac_acc

---
 rtl/booth_mac_if.sv | 28 ++
 rtl/booth_mac_acc.sv | 110 +++++++++++
 tb/tb_booth_mac_acc.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_if.sv
// Beat/result bus between a Booth multiplier, the frame accumulator and its consumer.
// Both directions use valid/ready: a transfer happens on a rising clk edge where valid
// and ready are both 1. The sender holds its payload steady while valid=1 and ready=0.
interface booth_mac_if #(
  parameter int WIDTH = 12,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   in_p;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_W-1:0]     out_acc;
  logic [LEN_W-1:0]     out_count;
  logic                 ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_count, ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, ovf
  );
endinterface

// File: rtl/booth_mac_acc.sv
// Frame accumulator for signed Booth products: sums beats until last, then holds the result.
// Optional macro BOOTH_MAC_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module booth_mac_acc #(
  parameter int WIDTH = 12,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  booth_mac_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [LEN_W-1:0]        count_q, count_d;
  logic                    ovf_q, ovf_d;

  logic                    accept;
  logic                    add_ovf;
  logic                    beat_last;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] add_res;
  logic [LEN_W-1:0]        count_inc;

  // Held low during reset so no beat can be taken while the block is being cleared.
  assign bus.in_ready = rst_n && (state_q != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;

  assign addend    = ACC_W'($signed(bus.in_p));
  assign sum       = $signed(acc_q) + addend;
  assign add_ovf   = (addend[ACC_W-1] == acc_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign count_inc = count_q + LEN_W'(1);
  // A full counter closes the frame so the beat count never wraps.
  assign beat_last = bus.in_last || (&count_inc);

`ifdef BOOTH_MAC_SAT_EN
  // Overflow direction follows the addend sign, since both operands share it.
  assign add_res = add_ovf ? (addend[ACC_W-1] ? $signed(ACC_MIN) : $signed(ACC_MAX)) : sum;
`else
  assign add_res = sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d   = add_res;
            count_d = count_inc;
            ovf_d   = ovf_q | add_ovf;
            state_d = beat_last ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_acc   = acc_q;
  assign bus.out_count = count_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: default, narrow-accumulator and short-counter instances.
module tb_booth_mac_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_clear, o_clear, f_clear;
  logic [1:0] m_state, o_state, f_state;
  int         n_tests = 0;
  int         n_fail  = 0;

`ifdef BOOTH_MAC_SAT_EN
  localparam longint OVF_POS_ACC  = 8388607;
  localparam longint OVF_NEG_ACC  = -8388608;
  localparam longint OVF_CONT_ACC = -8388603;
`else
  localparam longint OVF_POS_ACC  = -8388608;
  localparam longint OVF_NEG_ACC  = 8388607;
  localparam longint OVF_CONT_ACC = -8388604;
`endif

  always #5 clk = ~clk;

  booth_mac_if #(.WIDTH(12), .ACC_W(32), .LEN_W(8)) m_if ();
  booth_mac_if #(.WIDTH(12), .ACC_W(24), .LEN_W(8)) o_if ();
  booth_mac_if #(.WIDTH(12), .ACC_W(32), .LEN_W(2)) f_if ();

  booth_mac_acc #(.WIDTH(12), .ACC_W(32), .LEN_W(8)) u_main (
    .clk(clk), .rst_n(rst_n), .clear(m_clear), .bus(m_if.slave), .dbg_state(m_state)
  );
  booth_mac_acc #(.WIDTH(12), .ACC_W(24), .LEN_W(8)) u_ovf (
    .clk(clk), .rst_n(rst_n), .clear(o_clear), .bus(o_if.slave), .dbg_state(o_state)
  );
  booth_mac_acc #(.WIDTH(12), .ACC_W(32), .LEN_W(2)) u_len (
    .clk(clk), .rst_n(rst_n), .clear(f_clear), .bus(f_if.slave), .dbg_state(f_state)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int sel, input logic v, input int p, input logic last);
    case (sel)
      0: begin m_if.in_valid = v; m_if.in_p = 24'(p); m_if.in_last = last; end
      1: begin o_if.in_valid = v; o_if.in_p = 24'(p); o_if.in_last = last; end
      default: begin f_if.in_valid = v; f_if.in_p = 24'(p); f_if.in_last = last; end
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    m_clear = 1'b0;
    o_clear = 1'b0;
    f_clear = 1'b0;
    beat(0, 1'b0, 0, 1'b0);
    beat(1, 1'b0, 0, 1'b0);
    beat(2, 1'b0, 0, 1'b0);
    m_if.out_ready = 1'b0;
    o_if.out_ready = 1'b0;
    f_if.out_ready = 1'b0;

    // reset state
    tick();
    chk("rst_in_ready", m_if.in_ready, 0);
    chk("rst_out_valid", m_if.out_valid, 0);
    chk("rst_acc", $signed(m_if.out_acc), 0);
    chk("rst_count", m_if.out_count, 0);
    chk("rst_ovf", m_if.ovf, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", m_if.in_ready, 1);
    chk("post_rst_state", m_state, 0);

    // basic frame: 100, -15, 2047*2047
    beat(0, 1'b1, 100, 1'b0);
    tick();
    chk("basic_state_accum", m_state, 1);
    chk("basic_acc1", $signed(m_if.out_acc), 100);
    beat(0, 1'b1, -15, 1'b0);
    tick();
    beat(0, 1'b1, 4190209, 1'b1);
    chk("basic_valid_early", m_if.out_valid, 0);
    chk("basic_acc2", $signed(m_if.out_acc), 85);
    tick();
    beat(0, 1'b0, 0, 1'b0);
    chk("basic_out_valid", m_if.out_valid, 1);
    chk("basic_out_acc", $signed(m_if.out_acc), 4190294);
    chk("basic_out_count", m_if.out_count, 3);
    chk("basic_ovf", m_if.ovf, 0);
    chk("basic_in_ready", m_if.in_ready, 0);

    // back-pressure: offered beats must be ignored while holding
    beat(0, 1'b1, 999, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_out_valid", m_if.out_valid, 1);
      chk("bp_out_acc", $signed(m_if.out_acc), 4190294);
      chk("bp_out_count", m_if.out_count, 3);
      chk("bp_in_ready", m_if.in_ready, 0);
    end
    beat(0, 1'b0, 0, 1'b0);
    m_if.out_ready = 1'b1;
    tick();
    chk("pop_out_valid", m_if.out_valid, 0);
    chk("pop_state_idle", m_state, 0);
    chk("pop_acc", $signed(m_if.out_acc), 0);
    chk("pop_count", m_if.out_count, 0);
    chk("pop_in_ready", m_if.in_ready, 1);
    beat(0, 1'b1, 7, 1'b1);
    tick();
    beat(0, 1'b0, 0, 1'b0);
    chk("frame2_valid", m_if.out_valid, 1);
    chk("frame2_acc", $signed(m_if.out_acc), 7);
    chk("frame2_count", m_if.out_count, 1);
    tick();
    chk("frame2_popped", m_if.out_valid, 0);

    // clear coinciding with an accepted beat
    m_if.out_ready = 1'b0;
    beat(0, 1'b1, 50, 1'b0);
    tick();
    chk("clr_pre_acc", $signed(m_if.out_acc), 50);
    beat(0, 1'b1, 60, 1'b0);
    m_clear = 1'b1;
    tick();
    m_clear = 1'b0;
    chk("clr_acc", $signed(m_if.out_acc), 0);
    chk("clr_count", m_if.out_count, 0);
    chk("clr_state", m_state, 0);
    beat(0, 1'b1, 5, 1'b1);
    tick();
    beat(0, 1'b0, 0, 1'b0);
    chk("clr_next_valid", m_if.out_valid, 1);
    chk("clr_next_acc", $signed(m_if.out_acc), 5);
    chk("clr_next_count", m_if.out_count, 1);

    // clear while holding a result
    m_clear = 1'b1;
    tick();
    m_clear = 1'b0;
    chk("clr_hold_valid", m_if.out_valid, 0);
    chk("clr_hold_acc", $signed(m_if.out_acc), 0);

    // asynchronous reset while holding a result
    beat(0, 1'b1, 9, 1'b1);
    tick();
    beat(0, 1'b0, 0, 1'b0);
    chk("rsthold_valid_pre", m_if.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rsthold_valid", m_if.out_valid, 0);
    chk("rsthold_acc", $signed(m_if.out_acc), 0);
    chk("rsthold_in_ready", m_if.in_ready, 0);
    #1 rst_n = 1'b1;
    tick();
    chk("rsthold_ready_after", m_if.in_ready, 1);
    chk("rsthold_no_result", m_if.out_valid, 0);
    chk("rsthold_count", m_if.out_count, 0);

    // overflow, 24-bit accumulator, positive direction
    beat(1, 1'b1, 4194304, 1'b0);
    tick();
    chk("ovf_acc1", $signed(o_if.out_acc), 4194304);
    chk("ovf_flag1", o_if.ovf, 0);
    beat(1, 1'b1, 4194304, 1'b1);
    tick();
    beat(1, 1'b0, 0, 1'b0);
    chk("ovf_valid", o_if.out_valid, 1);
    chk("ovf_acc", $signed(o_if.out_acc), OVF_POS_ACC);
    chk("ovf_flag", o_if.ovf, 1);
    o_if.out_ready = 1'b1;
    tick();
    o_if.out_ready = 1'b0;
    chk("ovf_pop_flag", o_if.ovf, 0);
    chk("ovf_pop_acc", $signed(o_if.out_acc), 0);

    // negative direction: exact minimum, then past it, then continue
    beat(1, 1'b1, -4194304, 1'b0);
    tick();
    tick();
    chk("neg_min_acc", $signed(o_if.out_acc), -8388608);
    chk("neg_min_flag", o_if.ovf, 0);
    beat(1, 1'b1, -1, 1'b0);
    tick();
    chk("neg_ovf_acc", $signed(o_if.out_acc), OVF_NEG_ACC);
    chk("neg_ovf_flag", o_if.ovf, 1);
    beat(1, 1'b1, 5, 1'b1);
    tick();
    beat(1, 1'b0, 0, 1'b0);
    chk("neg_cont_acc", $signed(o_if.out_acc), OVF_CONT_ACC);
    chk("neg_cont_flag", o_if.ovf, 1);
    chk("neg_cont_count", o_if.out_count, 4);

    // forced end with a 2-bit beat counter
    beat(2, 1'b1, 1, 1'b0);
    tick();
    tick();
    chk("len_valid_early", f_if.out_valid, 0);
    chk("len_count2", f_if.out_count, 2);
    tick();
    beat(2, 1'b0, 0, 1'b0);
    chk("len_valid", f_if.out_valid, 1);
    chk("len_count", f_if.out_count, 3);
    chk("len_acc", $signed(f_if.out_acc), 3);
    chk("len_in_ready", f_if.in_ready, 0);
    f_if.out_ready = 1'b1;
    tick();
    chk("len_pop_valid", f_if.out_valid, 0);
    chk("len_pop_count", f_if.out_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
